acc_alu_seq: RTL
================

Name: acc_alu_seq

Overview:
Parametrised, clocked successor to the combinational accumulator ALU. It holds its own accumulator (ACC), carry flag (SC), zero flag and branch flag. It adds multi-cycle operations: shift or rotate by N, and shift-add multiply. The datapath issues one op per START pulse and waits for DONE; the program counter logic consumes BRANCH, where 1 means pc+2 and 0 means pc+1.

Parameters:
WIDTH, 8, datapath and accumulator width in bits (>= 4)
SHW, $clog2(WIDTH), width of the shift-amount field taken from OPERAND[SHW-1:0]

Ports:
CLK  input  1  clock, rising-edge
RESET_N  input  1  asynchronous active-low reset
START  input  1  op request; sampled only while BUSY=0
OP  input  4  opcode, sampled with START
OPERAND  input  WIDTH  register or immediate operand, already muxed upstream; sampled with START
ACC  output  WIDTH  accumulator (registered)
SC  output  1  carry / shift-carry flag (registered)
ZERO  output  1  1 when ACC==0 (registered, tracks ACC)
BRANCH  output  1  compare result: 0 = condition met, 1 = not met (registered)
PROD_HI  output  WIDTH  upper half of last MUL product (registered)
BUSY  output  1  multi-cycle op in progress
DONE  output  1  one-cycle pulse, op complete

Behaviour:
- Reset (async assert, sync release): state IDLE; ACC=0, SC=0, ZERO=1, BRANCH=0, PROD_HI=0, BUSY=0, DONE=0, counter=0. Assertion mid-operation aborts the op; no partial-result guarantee beyond reset values.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LDA, 6 SLN, 7 SRN, 8 ROLN, 9 MUL, 10 CEQ, 11 CGE, 12 CNE, 13 CLC, 14 SEC, 15 NOP.
- FSM states: IDLE, SHIFT, MUL.
- Single-cycle ops (0-5, 10-15): executed on the START edge in IDLE. DONE=1 in the following cycle; BUSY stays 0. A new START may be accepted in the same cycle DONE is high, giving back-to-back issue.
- ADD: {SC,ACC} <= ACC + OPERAND + SC.
- SUB: {SC,ACC} <= ACC + ~OPERAND + SC. Caller sets SC=1 (SEC) for true subtract.
- AND/OR/XOR: ACC <= ACC op OPERAND; SC unchanged.
- LDA: ACC <= OPERAND; SC unchanged.
- Compares:
  - CEQ: BRANCH <= (OPERAND==ACC) ? 0 : 1.
  - CGE: BRANCH <= (OPERAND>=ACC, unsigned) ? 0 : 1.
  - CNE: BRANCH <= (OPERAND!=ACC) ? 0 : 1.
  - Compares leave ACC and SC untouched.
- BRANCH changes only on compare ops and holds otherwise. CLC: SC<=0. SEC: SC<=1. NOP: no state change but still pulses DONE.
- SLN/SRN/ROLN, with n = OPERAND[SHW-1:0]:
  - n=0: behaves as single-cycle op, no state change.
  - n>0: enter SHIFT with counter=n. BUSY=1 from the next cycle; one bit per cycle.
  - SLN per cycle: {SC,ACC} <= {ACC,SC}.
  - SRN per cycle: {ACC,SC} <= {SC,ACC}.
  - ROLN per cycle: ACC <= {ACC[WIDTH-2:0],ACC[WIDTH-1]}; SC unchanged.
  - Counter decrements each cycle. After the n-th step, return to IDLE, BUSY=0, DONE=1 in that same following cycle.
  - Total: START edge + n cycles BUSY + DONE cycle.
- MUL: unsigned ACC*OPERAND via shift-add over exactly WIDTH cycles in state MUL (BUSY=1).
  - Multiplicand is latched at START.
  - On completion: ACC <= product[WIDTH-1:0], PROD_HI <= product[2W-1:W], SC <= |product[2W-1:W] (overflow flag).
  - Intermediate values never appear on ACC; ACC holds its old value until the completion edge.
- ZERO is recomputed from the next ACC value on every edge that writes ACC.
- START while BUSY=1 is ignored entirely: no queueing, no error.
- OP/OPERAND changes during BUSY have no effect; all operands are captured at START.
- Undefined opcodes: none, since all 16 codes are decoded.

Test Plan:
- Reset with RESET_N low mid-MUL (ACC=8'h0F, OPERAND=8'h11, cycle 3) -> immediately ACC=0, ZERO=1, BUSY=0, DONE=0; after release, LDA 8'hA5 -> ACC=A5, ZERO=0, DONE pulse 1 cycle later.
- CLC; LDA 8'hF0; ADD 8'h20 -> ACC=8'h10, SC=1; SEC; SUB 8'h10 -> ACC=8'h00, SC=1, ZERO=1; back-to-back issue with START held on DONE cycles.
- LDA 8'b1011_0011; SEC; SLN n=1 -> ACC=8'b0110_0111, SC=1, BUSY for exactly 1 cycle; ROLN n=3 on 8'h81 -> 8'h0C after 3 BUSY cycles; SLN n=0 -> DONE next cycle, ACC unchanged.
- LDA 8'hFF; MUL 8'hFF -> BUSY exactly 8 cycles, START pulses during BUSY ignored; then ACC=8'h01, PROD_HI=8'hFE, SC=1. MUL 8'h03 on ACC=8'h05 -> ACC=8'h0F, PROD_HI=0, SC=0.
- LDA 8'h40: CEQ 8'h40 -> BRANCH=0; CNE 8'h40 -> BRANCH=1; CGE 8'h3F -> BRANCH=1; CGE 8'h40 -> BRANCH=0; ACC/SC unchanged throughout.
- WIDTH=16 rerun: LDA 16'h8000; SRN n=15 with SC=0 -> ACC=16'h0001 after 15 BUSY cycles; MUL 16'hFFFF on 16'h0002 -> ACC=16'hFFFE, PROD_HI=16'h0001, SC=1.

Source files
------------

// File: rtl/acc_alu_seq_if.sv
// Request/response bundle between the datapath sequencer and the accumulator ALU.
interface acc_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [3:0]       OP;
  logic [WIDTH-1:0] OPERAND;
  logic [WIDTH-1:0] ACC;
  logic             SC;
  logic             ZERO;
  logic             BRANCH;
  logic [WIDTH-1:0] PROD_HI;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, OP, OPERAND,
    input  ACC, SC, ZERO, BRANCH, PROD_HI, BUSY, DONE
  );

  modport slave (
    input  START, OP, OPERAND,
    output ACC, SC, ZERO, BRANCH, PROD_HI, BUSY, DONE
  );
endinterface

// File: rtl/acc_alu_seq.sv
// Clocked accumulator ALU: single-cycle logic/arith/compare ops plus
// multi-cycle shift/rotate-by-N and shift-add multiply.
module acc_alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  acc_alu_seq_if.slave  bus
);
  localparam int CW = SHW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_MUL   = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_LDA  = 4'd5;
  localparam logic [3:0] OP_SLN  = 4'd6;
  localparam logic [3:0] OP_SRN  = 4'd7;
  localparam logic [3:0] OP_ROLN = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_CEQ  = 4'd10;
  localparam logic [3:0] OP_CGE  = 4'd11;
  localparam logic [3:0] OP_CNE  = 4'd12;
  localparam logic [3:0] OP_CLC  = 4'd13;
  localparam logic [3:0] OP_SEC  = 4'd14;

  logic [1:0]         state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [3:0]         shop_r, shop_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [2*WIDTH-1:0] prod_r, prod_s;
  logic [WIDTH-1:0]   acc_r, acc_s;
  logic [WIDTH-1:0]   prod_hi_r, prod_hi_s;
  logic               sc_r, sc_s;
  logic               zero_r, zero_s;
  logic               branch_r, branch_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  logic [WIDTH:0]     add_s, sub_s, mul_sum_s;
  logic [2*WIDTH-1:0] mul_step_s;
  logic [SHW-1:0]     shamt_s;

  // Next-state and datapath decode for all ops.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    shop_s    = shop_r;
    mcand_s   = mcand_r;
    prod_s    = prod_r;
    acc_s     = acc_r;
    sc_s      = sc_r;
    branch_s  = branch_r;
    prod_hi_s = prod_hi_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    shamt_s   = bus.OPERAND[SHW-1:0];
    add_s     = {1'b0, acc_r} + {1'b0, bus.OPERAND} + {{WIDTH{1'b0}}, sc_r};
    sub_s     = {1'b0, acc_r} + {1'b0, ~bus.OPERAND} + {{WIDTH{1'b0}}, sc_r};
    // prod_r holds {partial sum, remaining multiplier bits}; low bit selects the add.
    mul_sum_s  = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                 (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    mul_step_s = {mul_sum_s, prod_r[WIDTH-1:1]};

    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          done_s = 1'b1;
          case (bus.OP)
            OP_ADD:  {sc_s, acc_s} = add_s;
            OP_SUB:  {sc_s, acc_s} = sub_s;
            OP_AND:  acc_s = acc_r & bus.OPERAND;
            OP_OR:   acc_s = acc_r | bus.OPERAND;
            OP_XOR:  acc_s = acc_r ^ bus.OPERAND;
            OP_LDA:  acc_s = bus.OPERAND;
            OP_SLN, OP_SRN, OP_ROLN: begin
              if (shamt_s != {SHW{1'b0}}) begin
                state_s = ST_SHIFT;
                cnt_s   = {1'b0, shamt_s};
                shop_s  = bus.OP;
                busy_s  = 1'b1;
                done_s  = 1'b0;
              end else begin
                done_s = 1'b1;
              end
            end
            OP_MUL: begin
              state_s = ST_MUL;
              cnt_s   = CW'(WIDTH);
              mcand_s = bus.OPERAND;
              prod_s  = {{WIDTH{1'b0}}, acc_r};
              busy_s  = 1'b1;
              done_s  = 1'b0;
            end
            OP_CEQ:  branch_s = (bus.OPERAND == acc_r) ? 1'b0 : 1'b1;
            OP_CGE:  branch_s = (bus.OPERAND >= acc_r) ? 1'b0 : 1'b1;
            OP_CNE:  branch_s = (bus.OPERAND != acc_r) ? 1'b0 : 1'b1;
            OP_CLC:  sc_s = 1'b0;
            OP_SEC:  sc_s = 1'b1;
            default: done_s = 1'b1;
          endcase
        end else begin
          done_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        case (shop_r)
          OP_SLN:  {sc_s, acc_s} = {acc_r, sc_r};
          OP_SRN:  {acc_s, sc_s} = {sc_r, acc_r};
          default: acc_s = {acc_r[WIDTH-2:0], acc_r[WIDTH-1]};
        endcase
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_MUL: begin
        prod_s = mul_step_s;
        cnt_s  = cnt_r - CW'(1);
        // ACC is only written with the finished product.
        if (cnt_r == CW'(1)) begin
          acc_s     = mul_step_s[WIDTH-1:0];
          prod_hi_s = mul_step_s[2*WIDTH-1:WIDTH];
          sc_s      = |mul_step_s[2*WIDTH-1:WIDTH];
          state_s   = ST_IDLE;
          busy_s    = 1'b0;
          done_s    = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase

    zero_s = (acc_s == {WIDTH{1'b0}});
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      shop_r    <= 4'd0;
      mcand_r   <= {WIDTH{1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      sc_r      <= 1'b0;
      zero_r    <= 1'b1;
      branch_r  <= 1'b0;
      prod_hi_r <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shop_r    <= shop_s;
      mcand_r   <= mcand_s;
      prod_r    <= prod_s;
      acc_r     <= acc_s;
      sc_r      <= sc_s;
      zero_r    <= zero_s;
      branch_r  <= branch_s;
      prod_hi_r <= prod_hi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.ACC     = acc_r;
  assign bus.SC      = sc_r;
  assign bus.ZERO    = zero_r;
  assign bus.BRANCH  = branch_r;
  assign bus.PROD_HI = prod_hi_r;
  assign bus.BUSY    = busy_r;
  assign bus.DONE    = done_r;
endmodule
